tron_cycle_engine: RTL and testbench
====================================

TRON_CYCLE_ENGINE -- requirements
Module: tron_cycle_engine

Interface
REQ-001 Parameter NUM_PLAYERS, default 2, number of light cycles (2..4).
REQ-002 Parameter GRID_W, default 40, playfield width in cells.
REQ-003 Parameter GRID_H, default 30, playfield height in cells.
REQ-004 Parameter TRAIL_DEPTH, default 16, trail ring-buffer entries per player (power of 2, >=2).
REQ-005 Parameter COORD_W, default 6, coordinate width (2^COORD_W >= GRID_W, GRID_H). PW = clog2(NUM_PLAYERS).
REQ-006 clk  in  1  system clock; all logic on rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 start  in  1  begin/restart game; acted on only in IDLE or DONE.
REQ-009 tick  in  1  single-cycle movement step strobe.
REQ-010 dir_req  in  2*NUM_PLAYERS  requested direction per player (00 up, 01 right, 10 down, 11 left).
REQ-011 dir_valid  in  NUM_PLAYERS  per-player strobe qualifying dir_req.
REQ-012 query_valid, query_x, query_y  in  1, COORD_W, COORD_W  pixel-cell lookup request.
REQ-013 head_x, head_y  out  COORD_W*NUM_PLAYERS each  current head positions.
REQ-014 alive  out  NUM_PLAYERS  per-player alive flags.
REQ-015 game_over, draw, winner  out  1, 1, PW  result; winner valid only when game_over=1 and draw=0.
REQ-016 step_done, overrun  out  1, 1  step-commit pulse; sticky dropped-tick flag.
REQ-017 hit_valid, hit, hit_head, hit_player  out  1, 1, 1, PW  query response.

Function
REQ-018 FSM states IDLE, RUN, MOVE, CHECK, COMMIT, DONE; IDLE/DONE --start--> RUN; RUN --tick--> MOVE (1 cycle) --> CHECK (TRAIL_DEPTH cycles) --> COMMIT (1 cycle) --> RUN, or DONE if alive count <= 1.
REQ-019 Start loads player p head to x = (p+1)*GRID_W/(NUM_PLAYERS+1), y = GRID_H/2; direction right for even p, left for odd p; alive all 1; trails emptied; game_over, draw, winner, overrun cleared.
REQ-020 dir_valid latches dir_req into a per-player pending register in any state; last request before MOVE wins.
REQ-021 In MOVE each alive player's pending direction is applied unless it is the exact reverse of the current direction (ignored); next head = head +/-1 on one axis.
REQ-022 Without wrap, next head outside 0..GRID_W-1 / 0..GRID_H-1 (incl. underflow below 0) kills the player.
REQ-023 CHECK scans trail index 0..TRAIL_DEPTH-1, one index per cycle; only filled entries compare; next head equal to any player's filled entry kills that player.
REQ-024 Next head equal to another alive player's next head or pre-move head kills both involved (head-on and swap).
REQ-025 COMMIT: survivors' heads update, each survivor's pre-move head pushed into its ring buffer (oldest overwritten when full, fill saturates at TRAIL_DEPTH); dead heads freeze, their trails persist as obstacles; step_done high exactly this cycle.
REQ-026 Tick-to-head-update latency is TRAIL_DEPTH+2 cycles.
REQ-027 tick outside RUN is dropped and sets overrun; start and tick in the same cycle: start wins.
REQ-028 DONE: game_over=1; one survivor gives winner=index, draw=0; zero survivors give draw=1, winner=0.
REQ-029 Query: one cycle after query_valid, hit_valid=1; hit=1 if cell matches any head or filled trail entry; hit_head=1 if head match; hit_player=lowest matching index; all zero on miss.

Reset
REQ-030 Reset on any state, including mid-CHECK, returns to IDLE at that edge, discarding the step in progress.
REQ-031 Reset values: heads/directions as REQ-019, alive all 1, trails empty, pending directions = initial directions, game_over/draw/winner/step_done/overrun/hit_valid/hit/hit_head/hit_player all 0.

Configuration
REQ-032 Macro TRON_WRAP_EN defined: off-grid next head wraps to the opposite edge (x=-1 -> GRID_W-1, y=GRID_H -> 0), no wall death; undefined: REQ-022 applies.

Verification
REQ-033 Defaults, start, p0 dir_req left, 1 tick -> reversal ignored, p0 head (14,15), step_done pulse 18 cycles after tick.
REQ-034 Defaults, p0 right, p1 left, 7 ticks -> heads swap 19/20 on tick 7, both die, game_over=1, draw=1.
REQ-035 Defaults, p0 up, p1 down, 15 ticks -> p1 dies leaving y=29, p1 head frozen (26,29), winner=0, draw=0.
REQ-036 Same as REQ-035 with TRON_WRAP_EN -> p1 head (26,0), p0 head (13,0), both alive, game_over=0.
REQ-037 p0 sequence right, down, left, up (one tick each) -> p0 dies on tick 4 re-entering (13,15), winner=1; with TRAIL_DEPTH=2 -> p0 survives at (13,15).
REQ-038 After start, query (13,15) -> next cycle hit=1, hit_head=1, hit_player=0; tick while in CHECK -> overrun=1; reset asserted mid-CHECK -> state IDLE, outputs per REQ-031.

Source files
------------

// File: rtl/tron_cycle_engine.sv
// tron_cycle_engine: multi-player light-cycle game engine with per-player
// trail ring buffers, a serial collision scan and a single-cycle cell query.
// Optional feature macro: TRON_WRAP_EN (playfield edges wrap instead of kill).
module tron_cycle_engine #(
    parameter int NUM_PLAYERS = 2,
    parameter int GRID_W      = 40,
    parameter int GRID_H      = 30,
    parameter int TRAIL_DEPTH = 16,
    parameter int COORD_W     = 6,
    localparam int PW         = $clog2(NUM_PLAYERS)
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           start,
    input  logic                           tick,
    input  logic [2*NUM_PLAYERS-1:0]       dir_req,
    input  logic [NUM_PLAYERS-1:0]         dir_valid,
    input  logic                           query_valid,
    input  logic [COORD_W-1:0]             query_x,
    input  logic [COORD_W-1:0]             query_y,
    output logic [COORD_W*NUM_PLAYERS-1:0] head_x,
    output logic [COORD_W*NUM_PLAYERS-1:0] head_y,
    output logic [NUM_PLAYERS-1:0]         alive,
    output logic                           game_over,
    output logic                           draw,
    output logic [PW-1:0]                  winner,
    output logic                           step_done,
    output logic                           overrun,
    output logic                           hit_valid,
    output logic                           hit,
    output logic                           hit_head,
    output logic [PW-1:0]                  hit_player
);

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_MOVE, S_CHECK, S_COMMIT, S_DONE} state_t;

    localparam int IW = $clog2(TRAIL_DEPTH);
    localparam int FW = $clog2(TRAIL_DEPTH + 1);

    function automatic logic [COORD_W-1:0] start_x(input int unsigned p);
        return COORD_W'((p + 1) * GRID_W / (NUM_PLAYERS + 1));
    endfunction

    function automatic logic [1:0] start_dir(input int unsigned p);
        return p[0] ? 2'b11 : 2'b01;
    endfunction

    state_t               state, state_nxt;
    logic [COORD_W-1:0]   hx [NUM_PLAYERS];
    logic [COORD_W-1:0]   hy [NUM_PLAYERS];
    logic [COORD_W-1:0]   nx [NUM_PLAYERS];
    logic [COORD_W-1:0]   ny [NUM_PLAYERS];
    logic [1:0]           dir [NUM_PLAYERS];
    logic [1:0]           pend [NUM_PLAYERS];
    logic [COORD_W-1:0]   tx [NUM_PLAYERS][TRAIL_DEPTH];
    logic [COORD_W-1:0]   ty [NUM_PLAYERS][TRAIL_DEPTH];
    logic [IW-1:0]        wptr [NUM_PLAYERS];
    logic [FW-1:0]        fill [NUM_PLAYERS];
    logic [IW-1:0]        scan;
    logic [NUM_PLAYERS-1:0] kill;

    logic [1:0]           eff_dir [NUM_PLAYERS];
    logic [COORD_W-1:0]   cx [NUM_PLAYERS];
    logic [COORD_W-1:0]   cy [NUM_PLAYERS];
    logic [NUM_PLAYERS-1:0] wall_kill, meet_kill, scan_kill, survivors;
    logic [NUM_PLAYERS-1:0] q_head, q_trail, q_match;
    logic [PW-1:0]        q_player, surv_idx;
    logic [PW:0]          surv_cnt;
    logic                 start_ok;

    assign start_ok  = start && (state == S_IDLE || state == S_DONE);
    assign step_done = (state == S_COMMIT);

    // Next head per player; reversals are ignored, edges wrap or kill
    always_comb begin
        logic off;
        wall_kill = '0;
        meet_kill = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            eff_dir[p] = ((pend[p] ^ dir[p]) == 2'b10) ? dir[p] : pend[p];
            cx[p] = hx[p];
            cy[p] = hy[p];
            case (eff_dir[p])
                2'b00: begin
                    off   = (hy[p] == '0);
                    cy[p] = off ? COORD_W'(GRID_H - 1) : hy[p] - 1'b1;
                end
                2'b01: begin
                    off   = (hx[p] == COORD_W'(GRID_W - 1));
                    cx[p] = off ? '0 : hx[p] + 1'b1;
                end
                2'b10: begin
                    off   = (hy[p] == COORD_W'(GRID_H - 1));
                    cy[p] = off ? '0 : hy[p] + 1'b1;
                end
                default: begin
                    off   = (hx[p] == '0);
                    cx[p] = off ? COORD_W'(GRID_W - 1) : hx[p] - 1'b1;
                end
            endcase
`ifdef TRON_WRAP_EN
            wall_kill[p] = 1'b0;
`else
            // A wall-killed head stays put so it cannot fake a meet elsewhere
            wall_kill[p] = off;
            if (off) begin
                cx[p] = hx[p];
                cy[p] = hy[p];
            end
`endif
        end
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
                if (p != q && alive[p] && alive[q] &&
                    (((cx[p] == cx[q]) && (cy[p] == cy[q])) ||
                     ((cx[p] == hx[q]) && (cy[p] == hy[q])))) begin
                    meet_kill[p] = 1'b1;
                    meet_kill[q] = 1'b1;
                end
            end
        end
    end

    // Compare every alive next head against trail entry 'scan' of all players
    always_comb begin
        scan_kill = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            for (int unsigned q = 0; q < NUM_PLAYERS; q++) begin
                if (alive[p] && ((fill[q] == FW'(TRAIL_DEPTH)) || (FW'(scan) < fill[q])) &&
                    tx[q][scan] == nx[p] && ty[q][scan] == ny[p])
                    scan_kill[p] = 1'b1;
            end
        end
    end

    // Survivor count and lowest surviving index for the commit decision
    always_comb begin
        survivors = alive & ~kill;
        surv_cnt  = '0;
        surv_idx  = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (survivors[p])
                surv_cnt = surv_cnt + 1'b1;
            if (survivors[NUM_PLAYERS - 1 - p])
                surv_idx = PW'(NUM_PLAYERS - 1 - p);
        end
    end

    // Parallel cell lookup against all heads and filled trail entries
    always_comb begin
        q_head   = '0;
        q_trail  = '0;
        q_player = '0;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            q_head[p] = (hx[p] == query_x) && (hy[p] == query_y);
            for (int unsigned i = 0; i < TRAIL_DEPTH; i++) begin
                if (((fill[p] == FW'(TRAIL_DEPTH)) || (FW'(i) < fill[p])) &&
                    tx[p][i] == query_x && ty[p][i] == query_y)
                    q_trail[p] = 1'b1;
            end
        end
        q_match = q_head | q_trail;
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (q_match[NUM_PLAYERS - 1 - p])
                q_player = PW'(NUM_PLAYERS - 1 - p);
        end
    end

    // Flatten head registers onto the output buses
    always_comb begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            head_x[p*COORD_W +: COORD_W] = hx[p];
            head_y[p*COORD_W +: COORD_W] = hy[p];
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Step sequencing: RUN -> MOVE -> CHECK (one trail index per cycle) -> COMMIT
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE, S_DONE: if (start) state_nxt = S_RUN;
            S_RUN:          if (tick) state_nxt = S_MOVE;
            S_MOVE:         state_nxt = S_CHECK;
            S_CHECK:        if (scan == IW'(TRAIL_DEPTH - 1)) state_nxt = S_COMMIT;
            S_COMMIT:       state_nxt = (surv_cnt <= 1) ? S_DONE : S_RUN;
            default:        state_nxt = S_IDLE;
        endcase
    end

    // Direction requests are held until a MOVE consumes them
    always_ff @(posedge clk) begin
        for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
            if (reset)             pend[p] <= start_dir(p);
            else if (dir_valid[p]) pend[p] <= dir_req[2*p +: 2];
            else if (start_ok)     pend[p] <= start_dir(p);
        end
    end

    // Survivors push their pre-move head; fill bookkeeping marks validity
    always_ff @(posedge clk) begin
        if (state == S_COMMIT) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                if (survivors[p]) begin
                    tx[p][wptr[p]] <= hx[p];
                    ty[p][wptr[p]] <= hy[p];
                end
            end
        end
    end

    // Game state: heads, directions, kill accumulation, result flags
    always_ff @(posedge clk) begin
        if (reset || start_ok) begin
            for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                hx[p]   <= start_x(p);
                hy[p]   <= COORD_W'(GRID_H / 2);
                nx[p]   <= start_x(p);
                ny[p]   <= COORD_W'(GRID_H / 2);
                dir[p]  <= start_dir(p);
                wptr[p] <= '0;
                fill[p] <= '0;
            end
            alive     <= '1;
            kill      <= '0;
            scan      <= '0;
            game_over <= 1'b0;
            draw      <= 1'b0;
            winner    <= '0;
            overrun   <= 1'b0;
        end else begin
            if (tick && state != S_RUN)
                overrun <= 1'b1;
            case (state)
                S_MOVE: begin
                    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                        if (alive[p]) begin
                            nx[p]  <= cx[p];
                            ny[p]  <= cy[p];
                            dir[p] <= eff_dir[p];
                        end
                    end
                    kill <= (wall_kill | meet_kill) & alive;
                    scan <= '0;
                end
                S_CHECK: begin
                    kill <= kill | scan_kill;
                    scan <= scan + 1'b1;
                end
                S_COMMIT: begin
                    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
                        if (survivors[p]) begin
                            hx[p]   <= nx[p];
                            hy[p]   <= ny[p];
                            wptr[p] <= wptr[p] + 1'b1;
                            if (fill[p] != FW'(TRAIL_DEPTH))
                                fill[p] <= fill[p] + 1'b1;
                        end
                    end
                    alive <= survivors;
                    if (surv_cnt <= 1) begin
                        game_over <= 1'b1;
                        draw      <= (surv_cnt == 0);
                        winner    <= surv_idx;
                    end
                end
                default: ;
            endcase
        end
    end

    // Query response, registered one cycle after the request
    always_ff @(posedge clk) begin
        if (reset) begin
            hit_valid  <= 1'b0;
            hit        <= 1'b0;
            hit_head   <= 1'b0;
            hit_player <= '0;
        end else begin
            hit_valid  <= query_valid;
            hit        <= query_valid && (|q_match);
            hit_head   <= query_valid && (|q_head);
            hit_player <= query_valid ? q_player : '0;
        end
    end

endmodule

// File: tb/tb_tron_cycle_engine.sv
// tb_tron_cycle_engine: directed bench for tron_cycle_engine.
// u_dut uses default parameters; u_dut2 shares stimulus with TRAIL_DEPTH=2.
module tb_tron_cycle_engine;

    localparam int NP = 2;
    localparam int CW = 6;
    localparam int PW = 1;

    localparam logic [1:0] UP    = 2'b00;
    localparam logic [1:0] RIGHT = 2'b01;
    localparam logic [1:0] DOWN  = 2'b10;
    localparam logic [1:0] LEFT  = 2'b11;

    logic            clk = 1'b0;
    logic            reset, start, tick, query_valid;
    logic [2*NP-1:0] dir_req;
    logic [NP-1:0]   dir_valid;
    logic [CW-1:0]   query_x, query_y;

    logic [CW*NP-1:0] head_x, head_y, head_x2, head_y2;
    logic [NP-1:0]    alive, alive2;
    logic             game_over, draw, step_done, overrun, hit_valid, hit, hit_head;
    logic             game_over2, draw2, step_done2, overrun2, hit_valid2, hit2, hit_head2;
    logic [PW-1:0]    winner, hit_player, winner2, hit_player2;

    int unsigned checks   = 0;
    int unsigned failures = 0;
    int unsigned lat;

    tron_cycle_engine u_dut (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .dir_req(dir_req), .dir_valid(dir_valid),
        .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
        .head_x(head_x), .head_y(head_y), .alive(alive),
        .game_over(game_over), .draw(draw), .winner(winner),
        .step_done(step_done), .overrun(overrun),
        .hit_valid(hit_valid), .hit(hit), .hit_head(hit_head), .hit_player(hit_player)
    );

    tron_cycle_engine #(.TRAIL_DEPTH(2)) u_dut2 (
        .clk(clk), .reset(reset), .start(start), .tick(tick),
        .dir_req(dir_req), .dir_valid(dir_valid),
        .query_valid(query_valid), .query_x(query_x), .query_y(query_y),
        .head_x(head_x2), .head_y(head_y2), .alive(alive2),
        .game_over(game_over2), .draw(draw2), .winner(winner2),
        .step_done(step_done2), .overrun(overrun2),
        .hit_valid(hit_valid2), .hit(hit2), .hit_head(hit_head2), .hit_player(hit_player2)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cycle();
        cycle();
        reset = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cycle();
        start = 1'b0;
    endtask

    task automatic set_dir(input int p, input logic [1:0] d);
        dir_req[2*p +: 2] = d;
        dir_valid[p] = 1'b1;
        cycle();
        dir_valid = '0;
    endtask

    task automatic set_dirs(input logic [1:0] d0, input logic [1:0] d1);
        dir_req   = {d1, d0};
        dir_valid = 2'b11;
        cycle();
        dir_valid = '0;
    endtask

    // Count edges from the tick-sampling edge until step_done shows, bounded
    task automatic wait_step(output int unsigned n);
        n = 1;
        while (step_done !== 1'b1 && n < 100) begin
            cycle();
            n++;
        end
        if (n >= 100)
            check("step_timeout", {31'b0, step_done}, 32'd1);
    endtask

    task automatic do_tick(output int unsigned l);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        wait_step(l);
        cycle();
    endtask

    task automatic check_head(input string tag, input int p, input int ex, input int ey);
        check({tag, "_x"}, head_x[p*CW +: CW], ex);
        check({tag, "_y"}, head_y[p*CW +: CW], ey);
    endtask

    task automatic query(input int x, input int y);
        query_valid = 1'b1;
        query_x     = CW'(x);
        query_y     = CW'(y);
        cycle();
        query_valid = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; start = 1'b0; tick = 1'b0; query_valid = 1'b0;
        dir_req = '0; dir_valid = '0; query_x = '0; query_y = '0;
        do_reset();

        // Reset state
        check_head("rst_p0", 0, 13, 15);
        check_head("rst_p1", 1, 26, 15);
        check("rst_alive", alive, 3);
        check("rst_game_over", game_over, 0);
        check("rst_draw", draw, 0);
        check("rst_winner", winner, 0);
        check("rst_step_done", step_done, 0);
        check("rst_overrun", overrun, 0);
        check("rst_hit_valid", hit_valid, 0);
        check("rst_hit", hit, 0);
        check("rst_hit_head", hit_head, 0);
        check("rst_hit_player", hit_player, 0);

        // Queries on fresh heads
        do_start();
        query(13, 15);
        check("q0_valid", hit_valid, 1);
        check("q0_hit", hit, 1);
        check("q0_head", hit_head, 1);
        check("q0_player", hit_player, 0);
        query(26, 15);
        check("q1_hit_head", hit_head, 1);
        check("q1_player", hit_player, 1);
        query(0, 0);
        check("qmiss_valid", hit_valid, 1);
        check("qmiss_hit", hit, 0);
        check("qmiss_head", hit_head, 0);
        cycle();
        check("q_idle_valid", hit_valid, 0);

        // Reversal request ignored, step latency
        set_dir(0, LEFT);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        wait_step(lat);
        check("rev_latency", lat, 18);
        check("rev_head_before_commit", head_x[CW-1:0], 13);
        cycle();
        check("rev_step_done_low", step_done, 0);
        check_head("rev_p0", 0, 14, 15);
        check_head("rev_p1", 1, 25, 15);
        query(13, 15);
        check("qtrail_hit", hit, 1);
        check("qtrail_head", hit_head, 0);
        check("qtrail_player", hit_player, 0);
        query(26, 15);
        check("qtrail1_player", hit_player, 1);

        // Head swap on tick 7: both die, draw
        do_reset();
        do_start();
        repeat (6) do_tick(lat);
        check("swap6_alive", alive, 3);
        check_head("swap6_p0", 0, 19, 15);
        check_head("swap6_p1", 1, 20, 15);
        do_tick(lat);
        check("swap_alive", alive, 0);
        check("swap_game_over", game_over, 1);
        check("swap_draw", draw, 1);
        check("swap_winner", winner, 0);
        check_head("swap_p0", 0, 19, 15);
        check_head("swap_p1", 1, 20, 15);

        // Restart from DONE
        do_start();
        check_head("restart_p0", 0, 13, 15);
        check("restart_alive", alive, 3);
        check("restart_game_over", game_over, 0);

        // Vertical run into the bottom wall
        set_dirs(UP, DOWN);
        repeat (14) do_tick(lat);
        check_head("vert14_p0", 0, 13, 1);
        check_head("vert14_p1", 1, 26, 29);
        check("vert14_alive", alive, 3);
        do_tick(lat);
`ifdef TRON_WRAP_EN
        check("wrap_alive", alive, 3);
        check("wrap_game_over", game_over, 0);
        check_head("wrap_p0", 0, 13, 0);
        check_head("wrap_p1", 1, 26, 0);
`else
        check("wall_alive", alive, 1);
        check("wall_game_over", game_over, 1);
        check("wall_draw", draw, 0);
        check("wall_winner", winner, 0);
        check_head("wall_p0", 0, 13, 0);
        check_head("wall_p1", 1, 26, 29);
`endif

        // Self-trail collision; shallow trail forgets the start cell
        do_reset();
        do_start();
        set_dir(0, RIGHT); do_tick(lat);
        set_dir(0, DOWN);  do_tick(lat);
        set_dir(0, LEFT);  do_tick(lat);
        check_head("loop3_p0", 0, 13, 16);
        set_dir(0, UP);    do_tick(lat);
        check("loop_alive", alive, 2);
        check("loop_game_over", game_over, 1);
        check("loop_draw", draw, 0);
        check("loop_winner", winner, 1);
        check_head("loop_p0", 0, 13, 16);
        check("d2_alive", alive2, 3);
        check("d2_game_over", game_over2, 0);
        check("d2_p0_x", head_x2[CW-1:0], 13);
        check("d2_p0_y", head_y2[CW-1:0], 15);

        // Tick dropped while in CHECK
        do_reset();
        do_start();
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        repeat (4) cycle();
        check("ovr_before", overrun, 0);
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("ovr_set", overrun, 1);
        wait_step(lat);
        check("ovr_step_seen", step_done, 1);
        cycle();
        repeat (40) cycle();
        check("ovr_single_move", head_x[CW-1:0], 14);
        check("ovr_sticky", overrun, 1);

        // Reset in the middle of CHECK discards the step
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        repeat (5) cycle();
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check_head("midrst_p0", 0, 13, 15);
        check_head("midrst_p1", 1, 26, 15);
        check("midrst_alive", alive, 3);
        check("midrst_overrun", overrun, 0);
        check("midrst_step_done", step_done, 0);
        check("midrst_game_over", game_over, 0);
        repeat (25) cycle();
        check("midrst_no_commit", head_x[CW-1:0], 13);
        check("midrst_idle_step", step_done, 0);

        // Tick in IDLE sets overrun; start with tick clears it and wins
        tick = 1'b1;
        cycle();
        tick = 1'b0;
        check("idle_tick_ovr", overrun, 1);
        start = 1'b1;
        tick  = 1'b1;
        cycle();
        start = 1'b0;
        tick  = 1'b0;
        check("start_wins_ovr", overrun, 0);
        check_head("start_wins_p0", 0, 13, 15);
        do_tick(lat);
        check("after_start_latency", lat, 18);
        check_head("after_start_p0", 0, 14, 15);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
